// File: rtl/hlcp_pkg.sv
// Shared constants and FSM encoding for the HLCP clock generator.
package hlcp_pkg;
  localparam int HLCP_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/hlcp_clkgen.sv
// Integer-period clock generator: divided clock level plus rising/falling strobes,
// with a shadowed ratio that only changes at period boundaries.
module hlcp_clkgen
  import hlcp_pkg::*;
#(
  parameter int CNT_W = HLCP_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_resetb,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             core_en,
  input  logic             sync_clr,
  output logic             div_clk,
  output logic             clk_r,
  output logic             clk_f,
  output logic             upd_ack,
  output logic             running
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   c_q, c_d;
  logic [CNT_W-1:0]   shadow_q, shadow_d;
  logic               div_clk_q, div_clk_d;
  logic               clk_r_q, clk_r_d;
  logic               clk_f_q, clk_f_d;
  logic               upd_ack_q, upd_ack_d;
  logic               running_q, running_d;

  // One extra bit so an all-ones ratio yields a period of 2^CNT_W.
  logic [CNT_W:0]     ps, h, c_ext, c_inc;

  always_comb begin
    ps    = {1'b0, shadow_q} + 1'b1;
    h     = (ps + 1'b1) >> 1;
    c_ext = {1'b0, c_q};
    c_inc = c_ext + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    shadow_d  = shadow_q;
    div_clk_d = 1'b0;
    clk_r_d   = 1'b0;
    clk_f_d   = 1'b0;
    upd_ack_d = 1'b0;
    running_d = 1'b0;
    case (state_q)
      IDLE: begin
        shadow_d = div_ratio;
        c_d      = '0;
        if (core_en) begin
          state_d   = RUN;
          clk_r_d   = 1'b1;
          div_clk_d = 1'b1;
          running_d = 1'b1;
        end
      end
      RUN: begin
        if (!core_en) begin
          state_d = IDLE;
          c_d     = '0;
        end else begin
          running_d = 1'b1;
          if (sync_clr || (c_inc == ps)) begin
            // Boundary: the new period's first cycle is always high with clk_r.
            c_d       = '0;
            shadow_d  = div_ratio;
            clk_r_d   = 1'b1;
            div_clk_d = 1'b1;
            upd_ack_d = (div_ratio != shadow_q);
          end else begin
            c_d       = c_q + 1'b1;
            clk_f_d   = (c_inc == h);
            div_clk_d = (c_inc < h);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_resetb) begin
      state_q   <= IDLE;
      c_q       <= '0;
      shadow_q  <= '0;
      div_clk_q <= 1'b0;
      clk_r_q   <= 1'b0;
      clk_f_q   <= 1'b0;
      upd_ack_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      shadow_q  <= shadow_d;
      div_clk_q <= div_clk_d;
      clk_r_q   <= clk_r_d;
      clk_f_q   <= clk_f_d;
      upd_ack_q <= upd_ack_d;
      running_q <= running_d;
    end
  end

  assign div_clk = div_clk_q;
  assign clk_r   = clk_r_q;
  assign clk_f   = clk_f_q;
  assign upd_ack = upd_ack_q;
  assign running = running_q;

endmodule

// File: tb/tb_hlcp_clkgen.sv
// Bench for hlcp_clkgen: period/phase reference model, directed scenarios and random traffic.
module tb_hlcp_clkgen;
  localparam int CNT_W = 8;

  logic             sys_clk = 1'b0;
  logic             sys_resetb;
  logic [CNT_W-1:0] div_ratio;
  logic             core_en;
  logic             sync_clr;
  logic             div_clk, clk_r, clk_f, upd_ack, running;

  int tests = 0;
  int fails = 0;

  // Reference model: period length and phase within the current period.
  bit m_run;
  int m_ph;
  int m_per;
  logic [4:0] m_exp;

  hlcp_clkgen #(.CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_resetb(sys_resetb), .div_ratio(div_ratio),
    .core_en(core_en), .sync_clr(sync_clr), .div_clk(div_clk), .clk_r(clk_r),
    .clk_f(clk_f), .upd_ack(upd_ack), .running(running)
  );

  always #5 sys_clk = ~sys_clk;

  wire [4:0] obs = {div_clk, clk_r, clk_f, upd_ack, running};

  // Advance one edge, update the model with the inputs seen at that edge, settle.
  task automatic tick();
    int np, hh;
    @(posedge sys_clk);
    if (!sys_resetb) begin
      m_run = 0; m_ph = 0; m_per = 1; m_exp = 5'b0;
    end else if (!m_run) begin
      m_per = int'(div_ratio) + 1;
      m_ph  = 0;
      if (core_en) begin m_run = 1; m_exp = 5'b11001; end
      else m_exp = 5'b0;
    end else if (!core_en) begin
      m_run = 0; m_ph = 0; m_exp = 5'b0;
    end else if (sync_clr || m_ph == m_per - 1) begin
      np    = int'(div_ratio) + 1;
      m_exp = {1'b1, 1'b1, 1'b0, np != m_per, 1'b1};
      m_per = np;
      m_ph  = 0;
    end else begin
      m_ph++;
      hh    = (m_per + 1) / 2;
      m_exp = {m_ph < hh, 1'b0, (m_per >= 2) && (m_ph == hh), 1'b0, 1'b1};
    end
    #1;
  endtask

  task automatic test_reset();
    sys_resetb = 0; core_en = 1; sync_clr = 0; div_ratio = 8'd3;
    repeat (3) begin
      tick();
      tests++;
      if (obs !== 5'b0) begin
        fails++; $display("FAIL reset obs=%b exp=00000", obs);
      end
    end
  endtask

  task automatic test_p1();
    sys_resetb = 1; div_ratio = 0; core_en = 1;
    repeat (10) begin
      tick();
      tests++;
      if (obs !== 5'b11001 || obs !== m_exp) begin
        fails++; $display("FAIL p1 obs=%b exp=11001", obs);
      end
    end
  endtask

  task automatic test_period(input int ratio, input string nm);
    logic [7:0] pat;
    core_en = 0; tick();
    div_ratio = ratio[CNT_W-1:0]; core_en = 1;
    pat = '0;
    for (int i = 0; i < 4 * (ratio + 1); i++) begin
      tick();
      if (i < 8) pat[7-i] = div_clk;
      tests++;
      if (obs !== m_exp) begin
        fails++; $display("FAIL %s cyc=%0d obs=%b exp=%b", nm, i, obs, m_exp);
      end
    end
    tests++;
    if (ratio == 3 && pat !== 8'b11001100) begin
      fails++; $display("FAIL %s_pattern obs=%b exp=11001100", nm, pat);
    end else if (ratio == 4 && pat !== 8'b11100111) begin
      fails++; $display("FAIL %s_pattern obs=%b exp=11100111", nm, pat);
    end
  endtask

  task automatic test_ratio_update();
    int acks = 0;
    core_en = 0; tick();
    div_ratio = 8'd3; core_en = 1;
    tick(); tick();          // now at phase 1
    div_ratio = 8'd7;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (upd_ack) acks++;
      tests++;
      if (obs !== m_exp) begin
        fails++; $display("FAIL ratio_update cyc=%0d obs=%b exp=%b", i, obs, m_exp);
      end
    end
    tests++;
    if (acks !== 1) begin
      fails++; $display("FAIL ratio_update_ack count=%0d exp=1", acks);
    end
  endtask

  task automatic test_sync_clr();
    int n;
    core_en = 0; tick();
    div_ratio = 8'd7; core_en = 1; tick();
    n = 0;
    while (m_ph != 5 && n < 50) begin tick(); n++; end
    sync_clr = 1; tick(); sync_clr = 0;
    tests++;
    if (clk_r !== 1'b1 || obs !== m_exp) begin
      fails++; $display("FAIL sync_clr obs=%b exp=%b", obs, m_exp);
    end
    n = 0;
    while (m_ph != 2 && n < 50) begin
      tick(); n++;
      tests++;
      if (obs !== m_exp) begin
        fails++; $display("FAIL sync_clr_run obs=%b exp=%b", obs, m_exp);
      end
    end
    core_en = 0; tick();
    tests++;
    if (obs !== 5'b0) begin
      fails++; $display("FAIL disable obs=%b exp=00000", obs);
    end
    core_en = 1; tick();
    tests++;
    if (obs !== 5'b11001) begin
      fails++; $display("FAIL reenable obs=%b exp=11001", obs);
    end
  endtask

  task automatic test_p256();
    int hi = 0;
    core_en = 0; tick();
    div_ratio = 8'hFF; core_en = 1;
    for (int i = 0; i < 256; i++) begin
      tick();
      hi += int'(div_clk);
      tests++;
      if (obs !== m_exp) begin
        fails++; $display("FAIL p256 cyc=%0d obs=%b exp=%b", i, obs, m_exp);
      end
    end
    tick();
    tests++;
    if (hi !== 128 || clk_r !== 1'b1) begin
      fails++; $display("FAIL p256_duty high=%0d clk_r=%b exp=128/1", hi, clk_r);
    end
    repeat (40) tick();
    sys_resetb = 0; tick(); sys_resetb = 1;
    tests++;
    if (obs !== 5'b0) begin
      fails++; $display("FAIL reset_mid obs=%b exp=00000", obs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sys_resetb = ($urandom_range(0, 199) != 0);
      core_en    = ($urandom_range(0, 59) != 0);
      sync_clr   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0)
        div_ratio = ($urandom_range(0, 7) == 0) ? 8'(($urandom_range(0, 255))) : 8'(($urandom_range(0, 9)));
      tick();
      tests++;
      if (obs !== m_exp) begin
        fails++; $display("FAIL random cyc=%0d obs=%b exp=%b", i, obs, m_exp);
      end
    end
  endtask

  initial begin
    sys_resetb = 0; core_en = 0; sync_clr = 0; div_ratio = '0;
    m_run = 0; m_ph = 0; m_per = 1; m_exp = '0;
    #2;
    test_reset();
    test_p1();
    test_period(3, "p4");
    test_period(4, "p5");
    test_period(1, "p2");
    test_ratio_update();
    test_sync_clr();
    test_p256();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
